// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read handshake between the fetch unit and memory
interface instr_fetch_unit_if #(parameter int WIDTH = 16);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR holder, imem read handshake with timeout, and jump/branch redirect for the multicycle core
module instr_fetch_unit #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               ACK_TIMEOUT = 15
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    PCwrt,
  input  logic                    IRwrt,
  input  logic                    branch,
  input  logic                    BNEoBEQ,
  input  logic [1:0]              jump,
  input  logic                    aluZero,
  input  logic [WIDTH-1:0]        sextImm,
  input  logic [WIDTH-1:0]        jrTarget,
  instr_fetch_unit_if.master      bus,
  output logic [3:0]              op,
  output logic [3:0]              func,
  output logic [WIDTH-1:0]        pc,
  output logic                    fetchBusy,
  output logic                    irValid,
  output logic                    fetchErr
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0]       TIMEOUT = 8'(ACK_TIMEOUT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  state_t           state;
  logic [WIDTH-1:0] ir, pendTgt, target;
  logic [7:0]       cnt;
  logic             pend, jmpAbs, jmpReg, taken, redir;
  assign jmpAbs = jump == 2'b01;
  assign jmpReg = jump == 2'b10;
  assign taken  = branch && (BNEoBEQ ? !aluZero : aluZero);
  assign redir  = jmpAbs || jmpReg || taken;
  assign target = jmpAbs ? {pc[WIDTH-1:12], ir[11:0]} : jmpReg ? jrTarget : pc + sextImm;
  assign op            = ir[WIDTH-1 -: 4];
  assign func          = ir[3:0];
  assign fetchBusy     = state == WAIT;
  assign bus.imem_addr = pc;
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ir           <= '0;
      bus.imem_req <= 1'b0;
      irValid      <= 1'b0;
      fetchErr     <= 1'b0;
      pend         <= 1'b0;
      pendTgt      <= '0;
      cnt          <= '0;
    end else begin
      irValid <= 1'b0;
      if (state == IDLE) begin
        // a redirect pre-empts a fetch start; control re-issues the fetch
        if (redir) pc <= target;
        else if (PCwrt && IRwrt) begin
          state        <= WAIT;
          bus.imem_req <= 1'b1;
          cnt          <= '0;
        end
      end else if (bus.imem_ack) begin
        ir           <= bus.imem_rdata;
        pc           <= redir ? target : pend ? pendTgt : pc + ONE;
        irValid      <= 1'b1;
        state        <= IDLE;
        bus.imem_req <= 1'b0;
        pend         <= 1'b0;
        cnt          <= '0;
      end else if (cnt + 8'd1 == TIMEOUT) begin
        state        <= IDLE;
        bus.imem_req <= 1'b0;
        fetchErr     <= 1'b1;
        pend         <= 1'b0;
        cnt          <= '0;
      end else begin
        cnt <= cnt + 8'd1;
        if (redir) begin
          pend    <= 1'b1;
          pendTgt <= target;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed-vector bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        reset, PCwrt, IRwrt, branch, BNEoBEQ, aluZero;
  logic [1:0]  jump;
  logic [15:0] sextImm, jrTarget;
  logic [3:0]  op, func;
  logic [15:0] pc;
  logic        fetchBusy, irValid, fetchErr;
  int cmps = 0;
  int errs = 0;
  instr_fetch_unit_if #(.WIDTH(16)) bus();
  instr_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .ACK_TIMEOUT(15)) dut (
    .CLK(CLK), .reset(reset), .PCwrt(PCwrt), .IRwrt(IRwrt), .branch(branch),
    .BNEoBEQ(BNEoBEQ), .jump(jump), .aluZero(aluZero), .sextImm(sextImm),
    .jrTarget(jrTarget), .bus(bus), .op(op), .func(func), .pc(pc),
    .fetchBusy(fetchBusy), .irValid(irValid), .fetchErr(fetchErr));
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idleIn();
    reset = 1'b1; PCwrt = 1'b0; IRwrt = 1'b0; branch = 1'b0; BNEoBEQ = 1'b0;
    aluZero = 1'b0; jump = 2'b00; sextImm = '0; jrTarget = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
  endtask

  task automatic setPc(input logic [15:0] v);
    jump = 2'b10; jrTarget = v; tick(); jump = 2'b00;
  endtask

  task automatic doFetch(input logic [15:0] data, input int lat);
    PCwrt = 1'b1; IRwrt = 1'b1; tick(); PCwrt = 1'b0; IRwrt = 1'b0;
    for (int i = 1; i < lat; i++) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = data; tick(); bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idleIn(); reset = 1'b0; tick(); tick(); reset = 1'b1;
    cmps++; if (pc !== 16'h0000) begin errs++; $display("FAIL reset_pc got %h exp 0000", pc); end
    cmps++; if ({op, func} !== 8'h00) begin errs++; $display("FAIL reset_opfunc got %h exp 00", {op, func}); end
    cmps++; if ({bus.imem_req, fetchBusy, irValid, fetchErr} !== 4'b0000) begin errs++; $display("FAIL reset_flags got %b exp 0000", {bus.imem_req, fetchBusy, irValid, fetchErr}); end
  endtask

  task automatic test_fetch();
    PCwrt = 1'b1; IRwrt = 1'b1; tick(); PCwrt = 1'b0; IRwrt = 1'b0;
    cmps++; if ({bus.imem_req, fetchBusy} !== 2'b11 || bus.imem_addr !== 16'h0000) begin errs++; $display("FAIL fetch_req got req/busy %b addr %h exp 11 0000", {bus.imem_req, fetchBusy}, bus.imem_addr); end
    tick();
    cmps++; if (bus.imem_req !== 1'b1 || irValid !== 1'b0) begin errs++; $display("FAIL fetch_hold got req %b irValid %b exp 1 0", bus.imem_req, irValid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5A37; tick(); bus.imem_ack = 1'b0;
    cmps++; if ({op, func} !== 8'h57 || pc !== 16'h0001) begin errs++; $display("FAIL fetch_done got op/func %h pc %h exp 57 0001", {op, func}, pc); end
    cmps++; if ({irValid, bus.imem_req, fetchBusy} !== 3'b100) begin errs++; $display("FAIL fetch_flags got %b exp 100", {irValid, bus.imem_req, fetchBusy}); end
    tick();
    cmps++; if (irValid !== 1'b0) begin errs++; $display("FAIL fetch_pulse got irValid %b exp 0", irValid); end
  endtask

  task automatic test_branch();
    setPc(16'h0010);
    cmps++; if (pc !== 16'h0010) begin errs++; $display("FAIL br_setup got %h exp 0010", pc); end
    branch = 1'b1; BNEoBEQ = 1'b0; aluZero = 1'b1; sextImm = 16'hFFFC; tick(); branch = 1'b0;
    cmps++; if (pc !== 16'h000C) begin errs++; $display("FAIL beq_taken got %h exp 000C", pc); end
    setPc(16'h0010);
    branch = 1'b1; BNEoBEQ = 1'b0; aluZero = 1'b0; sextImm = 16'hFFFC; tick(); branch = 1'b0;
    cmps++; if (pc !== 16'h0010) begin errs++; $display("FAIL beq_not_taken got %h exp 0010", pc); end
    branch = 1'b1; BNEoBEQ = 1'b1; aluZero = 1'b0; sextImm = 16'h0003; tick(); branch = 1'b0; BNEoBEQ = 1'b0;
    cmps++; if (pc !== 16'h0013) begin errs++; $display("FAIL bne_taken got %h exp 0013", pc); end
  endtask

  task automatic test_jump();
    setPc(16'h3004); doFetch(16'h4ABC, 1);
    cmps++; if (pc !== 16'h3005 || {op, func} !== 8'h4C) begin errs++; $display("FAIL jmp_setup got pc %h op/func %h exp 3005 4C", pc, {op, func}); end
    jump = 2'b01; tick(); jump = 2'b00;
    cmps++; if (pc !== 16'h3ABC) begin errs++; $display("FAIL jmp_abs got %h exp 3ABC", pc); end
    jump = 2'b10; jrTarget = 16'h1234; tick(); jump = 2'b00;
    cmps++; if (pc !== 16'h1234) begin errs++; $display("FAIL jmp_jr got %h exp 1234", pc); end
    jump = 2'b11; jrTarget = 16'h7777; tick(); jump = 2'b00;
    cmps++; if (pc !== 16'h1234) begin errs++; $display("FAIL jmp_11 got %h exp 1234", pc); end
    jump = 2'b01; branch = 1'b1; aluZero = 1'b1; sextImm = 16'h0005; tick(); jump = 2'b00; branch = 1'b0; aluZero = 1'b0;
    cmps++; if (pc !== 16'h1ABC) begin errs++; $display("FAIL jmp_over_br got %h exp 1ABC", pc); end
    jump = 2'b10; jrTarget = 16'h0050; PCwrt = 1'b1; IRwrt = 1'b1; tick(); jump = 2'b00; PCwrt = 1'b0; IRwrt = 1'b0;
    cmps++; if (pc !== 16'h0050 || bus.imem_req !== 1'b0) begin errs++; $display("FAIL redir_vs_fetch got pc %h req %b exp 0050 0", pc, bus.imem_req); end
    PCwrt = 1'b1; tick(); PCwrt = 1'b0;
    cmps++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL pcwrt_only got req %b exp 0", bus.imem_req); end
  endtask

  task automatic test_wrap();
    setPc(16'hFFFF); doFetch(16'h1111, 1);
    cmps++; if (pc !== 16'h0000 || irValid !== 1'b1) begin errs++; $display("FAIL wrap got pc %h irValid %b exp 0000 1", pc, irValid); end
  endtask

  task automatic test_pending();
    PCwrt = 1'b1; IRwrt = 1'b1; tick(); PCwrt = 1'b0; IRwrt = 1'b0;
    jump = 2'b10; jrTarget = 16'h0030; tick(); jrTarget = 16'h0040; tick(); jump = 2'b00;
    cmps++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin errs++; $display("FAIL pend_stable got req %b addr %h exp 1 0000", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2345; tick(); bus.imem_ack = 1'b0;
    cmps++; if (pc !== 16'h0040 || {op, func} !== 8'h25) begin errs++; $display("FAIL pend_apply got pc %h op/func %h exp 0040 25", pc, {op, func}); end
  endtask

  task automatic test_timeout();
    PCwrt = 1'b1; IRwrt = 1'b1; tick(); PCwrt = 1'b0; IRwrt = 1'b0;
    jump = 2'b10; jrTarget = 16'h0077; tick(); jump = 2'b00;
    for (int i = 1; i < 14; i++) tick();
    cmps++; if (bus.imem_req !== 1'b1 || fetchErr !== 1'b0) begin errs++; $display("FAIL to_before got req %b err %b exp 1 0", bus.imem_req, fetchErr); end
    tick();
    cmps++; if ({bus.imem_req, fetchBusy, fetchErr, irValid} !== 4'b0010) begin errs++; $display("FAIL to_abort got %b exp 0010", {bus.imem_req, fetchBusy, fetchErr, irValid}); end
    cmps++; if (pc !== 16'h0040 || {op, func} !== 8'h25) begin errs++; $display("FAIL to_state got pc %h op/func %h exp 0040 25", pc, {op, func}); end
    tick(); tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF; tick(); bus.imem_ack = 1'b0;
    cmps++; if (irValid !== 1'b0 || pc !== 16'h0040 || {op, func} !== 8'h25 || fetchErr !== 1'b1) begin errs++; $display("FAIL to_late_ack got irValid %b pc %h op/func %h err %b exp 0 0040 25 1", irValid, pc, {op, func}, fetchErr); end
  endtask

  task automatic test_reset_mid_wait();
    PCwrt = 1'b1; IRwrt = 1'b1; tick(); PCwrt = 1'b0; IRwrt = 1'b0;
    jump = 2'b10; jrTarget = 16'h0099; tick(); jump = 2'b00;
    reset = 1'b0; tick(); reset = 1'b1;
    cmps++; if ({bus.imem_req, fetchBusy, fetchErr} !== 3'b000 || pc !== 16'h0000) begin errs++; $display("FAIL rst_wait got flags %b pc %h exp 000 0000", {bus.imem_req, fetchBusy, fetchErr}, pc); end
    doFetch(16'hA001, 1);
    cmps++; if (pc !== 16'h0001 || {op, func} !== 8'hA1) begin errs++; $display("FAIL rst_pend_lost got pc %h op/func %h exp 0001 A1", pc, {op, func}); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_wrap();
    test_pending();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit multicycle processor.
- Holds the PC and the instruction register (IR) and runs the instruction-memory read handshake.
- Supplies op/func to the main control FSM.
- Applies that FSM's PCwrt/IRwrt, branch, BNEoBEQ and jump commands to update the PC.
- Word-addressed: sequential PC step is +1.

Parameters:
WIDTH, 16, data/address width.
RESET_PC, 16'h0000, PC value after reset.
ACK_TIMEOUT, 15, max WAIT cycles without imem_ack before abort (1..255).

Ports:
CLK  input  1  clock, all state changes on posedge.
reset  input  1  synchronous, active-low; reset==0 at a posedge clears all state.
PCwrt  input  1  fetch strobe from control (fetch state).
IRwrt  input  1  IR load enable; fetch starts only when PCwrt&IRwrt.
branch  input  1  conditional-branch command pulse.
BNEoBEQ  input  1  0 = beq (taken on aluZero), 1 = bne (taken on !aluZero).
jump  input  2  00 none, 01 jump absolute, 10 jr, 11 ignored.
aluZero  input  1  ALU equality flag, sampled with branch.
sextImm  input  WIDTH  sign-extended branch offset from datapath.
jrTarget  input  WIDTH  register value for jr.
imem_ack  input  1  memory read-data valid.
imem_rdata  input  WIDTH  instruction word.
imem_req  output  1  read request, held high until ack or abort.
imem_addr  output  WIDTH  = PC while imem_req.
op  output  4  IR[15:12], combinational from IR.
func  output  4  IR[3:0], combinational from IR.
pc  output  WIDTH  current PC.
fetchBusy  output  1  high while a fetch is outstanding; control must stall.
irValid  output  1  one-cycle pulse when a new IR is loaded.
fetchErr  output  1  sticky timeout flag.

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC, IR=0, state IDLE, imem_req=0, fetchBusy=0, irValid=0, fetchErr=0.
  - Pending redirect cleared; wait counter cleared.
  - Reset during WAIT abandons the read: imem_req low from the next cycle.
- States: IDLE, WAIT.
- IDLE:
  - PCwrt&IRwrt=1 -> WAIT, imem_req=1 and fetchBusy=1 from the next cycle, imem_addr=pc.
  - PCwrt without IRwrt: no action.
- WAIT:
  - imem_req held and imem_addr stable until imem_ack.
  - On imem_ack: IR<=imem_rdata and pc<=pc+1 (mod 2^WIDTH; 16'hFFFF wraps to 0), unless a pending redirect exists, in which case pc<=redirect target. Then irValid=1 for exactly one cycle, state IDLE, imem_req=0, fetchBusy=0, counter cleared.
  - Ack latency: min 1 cycle after req rises; fetch-to-irValid latency = ack latency + 1.
- Timeout:
  - Counter increments each WAIT cycle without ack. Reaching ACK_TIMEOUT -> IDLE, imem_req=0, fetchErr=1 (sticky until reset).
  - pc and IR unchanged; no irValid.
  - Ack arriving in IDLE is ignored.
- Redirect, evaluated each cycle:
  - jump=01: target={pc[15:12], IR[11:0]}.
  - jump=10: target=jrTarget.
  - branch=1 and taken: target=pc+sextImm (pc already points at instr+1). Taken = BNEoBEQ ? !aluZero : aluZero.
  - Not taken: no change.
  - Priority: jump (01/10) over branch; jump=11 treated as none.
  - In IDLE: pc<=target next cycle.
  - In WAIT: target latched as pending and applied at ack. A later redirect in the same WAIT overwrites the pending one. Pending is dropped on timeout.
- Simultaneous IDLE fetch start and redirect: redirect wins, no request issued; control retries the fetch.
- Arithmetic: all PC sums are WIDTH-bit, overflow discarded.

Test Plan:
- Reset held low 2 cycles, then released -> pc=0000, op=0, func=0, imem_req=0, fetchErr=0; PCwrt&IRwrt at pc=0, ack after 2 cycles with 16'h5A37 -> op=5, func=7, pc=0001, single irValid pulse.
- pc=0010, beq with aluZero=1, sextImm=FFFC -> pc=000C; same with aluZero=0 -> pc=0010; bne with aluZero=0, sextImm=0003 -> pc=0013.
- IR=4ABC, pc=3005, jump=01 -> pc=3ABC; jump=10 with jrTarget=1234 -> pc=1234; jump=11 -> pc unchanged; jump=01 and taken branch together -> jump target.
- Fetch at pc=FFFF, ack=1 -> pc=0000; fetch with jump=10 (jrTarget=0040) asserted during WAIT -> after ack pc=0040, IR=rdata.
- ACK_TIMEOUT=15, no ack -> imem_req drops after 15 WAIT cycles, fetchErr=1, pc/IR unchanged; ack asserted 2 cycles later -> ignored.
- reset driven low mid-WAIT -> imem_req=0 next cycle, pc=RESET_PC, pending redirect lost, fetchErr cleared.
